// File: rtl/exec_ppn_table_if.sv
// Update channel of exec_ppn_table: request handshake plus completion ack/status.
// The requester side uses the master modport and the table uses the slave modport.
interface exec_ppn_table_if #(
    parameter int PPN_W = 20
);
    logic             upd_valid_i;
    logic             upd_ready_o;
    logic             upd_op_i;
    logic [PPN_W-1:0] upd_ppn_i;
    logic             upd_ack_o;
    logic [1:0]       upd_err_o;

    modport master (
        output upd_valid_i, upd_op_i, upd_ppn_i,
        input  upd_ready_o, upd_ack_o, upd_err_o
    );

    modport slave (
        input  upd_valid_i, upd_op_i, upd_ppn_i,
        output upd_ready_o, upd_ack_o, upd_err_o
    );
endinterface

// File: rtl/exec_ppn_table.sv
// Table of executable physical page numbers, checked combinationally against the D-side write PA.
// Define EXEC_PPN_FLUSH_EN to add flush_i, which clears the whole table in a single IDLE cycle.
module exec_ppn_table #(
    parameter int DEPTH = 8,
    parameter int PA_W  = 32,
    parameter int PPN_W = 20
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    exec_ppn_table_if.slave            upd_if,
    input  logic                       lock_i,
`ifdef EXEC_PPN_FLUSH_EN
    input  logic                       flush_i,
`endif
    input  logic [PA_W-1:0]            query_pa_i,
    output logic                       hit_exec_ppn_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [1:0] E_OK       = 2'd0;
    localparam logic [1:0] E_FULL     = 2'd1;
    localparam logic [1:0] E_NOTFOUND = 2'd2;
    localparam logic [1:0] E_LOCKED   = 2'd3;

    logic [1:0]       r_state;
    logic             r_alive;
    logic             r_op;
    logic [PPN_W-1:0] r_ppn;
    logic [DEPTH-1:0] r_valid;
    logic [PPN_W-1:0] r_tag [DEPTH];
    logic             r_match;
    logic [IDX_W-1:0] r_match_idx;
    logic             r_free;
    logic [IDX_W-1:0] r_free_idx;
    logic [CNT_W-1:0] r_count;

    logic             w_flush;
    logic             w_accept;
    logic             w_match;
    logic [IDX_W-1:0] w_match_idx;
    logic             w_free;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_set;
    logic             w_clr;
    logic [1:0]       w_err;
    logic             w_hit_tab;
    logic [PPN_W-1:0] w_query_ppn;
    logic             w_unused;

    assign w_query_ppn = query_pa_i[PA_W-1 -: PPN_W];
    assign w_unused    = ^query_pa_i[PA_W-PPN_W-1:0];

`ifdef EXEC_PPN_FLUSH_EN
    assign w_flush = r_alive && (r_state == S_IDLE) && flush_i && !lock_i;
`else
    assign w_flush = 1'b0;
`endif

    // r_alive keeps ready low through reset and lets it rise on the first edge after release.
    assign upd_if.upd_ready_o = r_alive && (r_state == S_IDLE) && !w_flush;
    assign w_accept           = upd_if.upd_valid_i && upd_if.upd_ready_o;

    // Descending scan so the lowest matching / free index is the one left standing.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_match     = 1'b0;
        w_match_idx = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == r_ppn)) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_err = E_OK;
        w_set = 1'b0;
        w_clr = 1'b0;
        if (r_state == S_COMMIT) begin
            if (lock_i) begin
                w_err = E_LOCKED;
            end else if (!r_op) begin
                if (!r_match) begin
                    if (r_free) w_set = 1'b1;
                    else        w_err = E_FULL;
                end
            end else if (r_match) begin
                w_clr = 1'b1;
            end else begin
                w_err = E_NOTFOUND;
            end
        end
    end

    assign upd_if.upd_ack_o = (r_state == S_COMMIT);
    assign upd_if.upd_err_o = w_err;

    always_comb begin
        w_hit_tab = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_tag[i] == w_query_ppn)) w_hit_tab = 1'b1;
        end
    end

    // A latched insert blocks its page before commit; a latched remove keeps hitting until commit.
    assign hit_exec_ppn_o = w_hit_tab ||
                            (((r_state == S_SEARCH) || (r_state == S_COMMIT)) &&
                             !r_op && (r_ppn == w_query_ppn));

    assign count_o = r_count;
    assign full_o  = (r_count == CNT_W'(DEPTH));
    assign empty_o = (r_count == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_alive     <= 1'b0;
            r_op        <= 1'b0;
            r_ppn       <= '0;
            r_match     <= 1'b0;
            r_match_idx <= '0;
            r_free      <= 1'b0;
            r_free_idx  <= '0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= upd_if.upd_op_i;
                        r_ppn   <= upd_if.upd_ppn_i;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    r_match     <= w_match;
                    r_match_idx <= w_match_idx;
                    r_free      <= w_free;
                    r_free_idx  <= w_free_idx;
                    r_state     <= S_COMMIT;
                end
                S_COMMIT: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (w_set) begin
            r_valid[r_free_idx] <= 1'b1;
            r_count             <= r_count + CNT_W'(1);
        end else if (w_clr) begin
            r_valid[r_match_idx] <= 1'b0;
            r_count              <= r_count - CNT_W'(1);
        end
    end

    // NOTE: tag storage is not reset; a tag is only ever read through its valid bit, which is.
    always_ff @(posedge clk_i) begin
        if (w_set) r_tag[r_free_idx] <= r_ppn;
    end
endmodule

// File: tb/tb_exec_ppn_table.sv
// Self-checking bench for exec_ppn_table: directed corner cases plus random insert/remove/lock
// traffic compared against a set-of-PPNs reference model.
module tb_exec_ppn_table;
    localparam int DEPTH = 8;
    localparam int PA_W  = 32;
    localparam int PPN_W = 20;

    logic             clk;
    logic             rst_n;
    logic             lock;
    logic             flush;
    logic [PA_W-1:0]  query_pa;
    logic             hit;
    logic [3:0]       count;
    logic             full;
    logic             empty;

    int n_checks = 0;
    int n_errors = 0;

    logic [PPN_W-1:0] m_tab [$];

    exec_ppn_table_if #(.PPN_W(PPN_W)) upd_if ();

    exec_ppn_table #(.DEPTH(DEPTH), .PA_W(PA_W), .PPN_W(PPN_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .upd_if         (upd_if),
        .lock_i         (lock),
`ifdef EXEC_PPN_FLUSH_EN
        .flush_i        (flush),
`endif
        .query_pa_i     (query_pa),
        .hit_exec_ppn_o (hit),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_has(input logic [PPN_W-1:0] p);
        foreach (m_tab[i]) if (m_tab[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_idle_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'(m_tab.size()));
        check({tag, "_full"},  32'(full),  32'(m_tab.size() == DEPTH));
        check({tag, "_empty"}, 32'(empty), 32'(m_tab.size() == 0));
    endtask

    task automatic set_query(input logic [PPN_W-1:0] p);
        query_pa = {p, 12'($urandom)};
        #1;
    endtask

    // One full update transaction; all timing and result expectations come from the model.
    task automatic upd(input logic op, input logic [PPN_W-1:0] p, input bit lock_mid);
        bit         pre;
        logic [1:0] exp_err;
        pre = m_has(p);
        if (lock_mid)                         exp_err = 2'd3;
        else if (!op && pre)                  exp_err = 2'd0;
        else if (!op && m_tab.size() < DEPTH) exp_err = 2'd0;
        else if (!op)                         exp_err = 2'd1;
        else if (pre)                         exp_err = 2'd0;
        else                                  exp_err = 2'd2;

        @(negedge clk);
        check("ready_idle", 32'(upd_if.upd_ready_o), 32'd1);
        upd_if.upd_valid_i = 1'b1;
        upd_if.upd_op_i    = op;
        upd_if.upd_ppn_i   = p;

        @(negedge clk);
        upd_if.upd_op_i  = ~op;
        upd_if.upd_ppn_i = ~p;
        set_query(p);
        check("ack_search",   32'(upd_if.upd_ack_o),   32'd0);
        check("err_search",   32'(upd_if.upd_err_o),   32'd0);
        check("ready_search", 32'(upd_if.upd_ready_o), 32'd0);
        check("hit_search",   32'(hit), 32'(pre || !op));
        if (lock_mid) lock = 1'b1;

        @(negedge clk);
        upd_if.upd_valid_i = 1'b0;
        set_query(p);
        check("ack_commit", 32'(upd_if.upd_ack_o), 32'd1);
        check("err_commit", 32'(upd_if.upd_err_o), 32'(exp_err));
        check("hit_commit", 32'(hit), 32'(pre || !op));

        if (exp_err == 2'd0) begin
            if (!op && !pre) m_tab.push_back(p);
            if (op) foreach (m_tab[i]) if (m_tab[i] == p) begin m_tab.delete(i); break; end
        end

        @(negedge clk);
        lock = 1'b0;
        set_query(p);
        check("ack_after",   32'(upd_if.upd_ack_o),   32'd0);
        check("err_after",   32'(upd_if.upd_err_o),   32'd0);
        check("ready_after", 32'(upd_if.upd_ready_o), 32'd1);
        check("hit_after",   32'(hit), 32'(m_has(p)));
        check_idle_state("after");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_tab.delete();
        check("rst_ready", 32'(upd_if.upd_ready_o), 32'd0);
        check("rst_ack",   32'(upd_if.upd_ack_o),   32'd0);
        check("rst_err",   32'(upd_if.upd_err_o),   32'd0);
        check("rst_hit",   32'(hit),   32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full",  32'(full),  32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_rise", 32'(upd_if.upd_ready_o), 32'd1);
    endtask

    initial begin
        rst_n              = 1'b0;
        lock               = 1'b0;
        flush              = 1'b0;
        query_pa           = '0;
        upd_if.upd_valid_i = 1'b0;
        upd_if.upd_op_i    = 1'b0;
        upd_if.upd_ppn_i   = '0;

        do_reset();

        // Single insert, query with an in-page offset.
        upd(1'b0, 20'h12345, 1'b0);
        query_pa = 32'h12345ABC;
        #1;
        check("q_12345abc", 32'(hit), 32'd1);
        check("q_count1",   32'(count), 32'd1);

        // Fill to capacity, then one more.
        do_reset();
        for (int i = 0; i < DEPTH; i++) upd(1'b0, 20'h10000 + 20'(i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        upd(1'b0, 20'h1FFFF, 1'b0);
        check("fill_count8", 32'(count), 32'd8);

        // Remove absent, then insert/remove the same page.
        do_reset();
        upd(1'b1, 20'h00AAA, 1'b0);
        upd(1'b0, 20'h00AAA, 1'b0);
        upd(1'b1, 20'h00AAA, 1'b0);

        // Lock rising after accept.
        upd(1'b0, 20'h00BBB, 1'b1);

        // Reset while an insert sits in SEARCH.
        upd(1'b0, 20'h00DDD, 1'b0);
        @(negedge clk);
        upd_if.upd_valid_i = 1'b1;
        upd_if.upd_op_i    = 1'b0;
        upd_if.upd_ppn_i   = 20'h0CCC0;
        @(negedge clk);
        upd_if.upd_valid_i = 1'b0;
        set_query(20'h0CCC0);
        check("abort_pending_hit", 32'(hit), 32'd1);
        rst_n = 1'b0;
        #1;
        m_tab.delete();
        check("abort_hit",   32'(hit),   32'd0);
        check("abort_ack",   32'(upd_if.upd_ack_o), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        @(negedge clk);
        check("abort_ack_rst", 32'(upd_if.upd_ack_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_rise", 32'(upd_if.upd_ready_o), 32'd1);
        check("abort_ack_post",   32'(upd_if.upd_ack_o),   32'd0);
        @(negedge clk);
        check("abort_ack_post2",  32'(upd_if.upd_ack_o),   32'd0);
        check_idle_state("abort");

`ifdef EXEC_PPN_FLUSH_EN
        for (int i = 0; i < 3; i++) upd(1'b0, 20'h20000 + 20'(i), 1'b0);
        @(negedge clk);
        flush              = 1'b1;
        upd_if.upd_valid_i = 1'b1;
        upd_if.upd_op_i    = 1'b0;
        upd_if.upd_ppn_i   = 20'h2FFFF;
        #1;
        check("flush_ready_low", 32'(upd_if.upd_ready_o), 32'd0);
        @(negedge clk);
        flush              = 1'b0;
        upd_if.upd_valid_i = 1'b0;
        m_tab.delete();
        set_query(20'h20001);
        check("flush_hit", 32'(hit), 32'd0);
        check_idle_state("flush");
        check("flush_not_accepted", 32'(upd_if.upd_ready_o), 32'd1);
        @(negedge clk);
        check("flush_no_ack", 32'(upd_if.upd_ack_o), 32'd0);
        for (int i = 0; i < 3; i++) upd(1'b0, 20'h20000 + 20'(i), 1'b0);
        @(negedge clk);
        flush = 1'b1;
        lock  = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        lock  = 1'b0;
        check("flush_locked_count", 32'(count), 32'd3);
`endif

        // Random traffic on a small page pool so FULL, NOTFOUND and duplicates all occur.
        for (int n = 0; n < 250; n++) begin
            logic [PPN_W-1:0] p;
            p = 20'h40000 + 20'($urandom_range(0, 11));
            upd(1'($urandom_range(0, 2) == 0), p, ($urandom_range(0, 9) == 0));
            p = 20'h40000 + 20'($urandom_range(0, 11));
            set_query(p);
            check("rand_probe", 32'(hit), 32'(m_has(p)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/exec_ppn_table.md
EXEC_PPN_TABLE -- requirements
Module: exec_ppn_table

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of executable-PPN entries, range 2..32.
REQ-002 SHALL have parameter PA_W, default 32: physical address width.
REQ-003 SHALL have parameter PPN_W, default 20: PPN width, PPN = query_pa_i[PA_W-1:PA_W-PPN_W] (4 KiB pages).
REQ-004 SHALL have one clock and one asynchronous, active-low reset; all state is clocked on the rising edge of clk_i.
REQ-005 clk_i  input  1  clock.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 upd_valid_i  input  1  update request valid.
REQ-008 upd_ready_o  output  1  update request accepted when high with upd_valid_i.
REQ-009 upd_op_i  input  1  0 = insert PPN as executable, 1 = remove PPN.
REQ-010 upd_ppn_i  input  PPN_W  PPN to insert or remove.
REQ-011 upd_ack_o  output  1  one-cycle completion pulse.
REQ-012 upd_err_o  output  2  status valid with upd_ack_o: 0 OK, 1 FULL, 2 NOTFOUND, 3 LOCKED.
REQ-013 lock_i  input  1  sticky LOCK; table frozen while high.
REQ-014 query_pa_i  input  PA_W  physical address to test, driven from the D-side write address.
REQ-015 hit_exec_ppn_o  output  1  combinational: the query PPN is executable or pending insert.
REQ-016 count_o  output  $clog2(DEPTH+1)  number of valid entries.
REQ-017 full_o / empty_o  output  1 each  count_o==DEPTH / count_o==0.

Function
REQ-018 SHALL hold an FSM with states IDLE, SEARCH and COMMIT; upd_ready_o SHALL be 1 only in IDLE.
REQ-019 Handshake: upd_valid_i&&upd_ready_o SHALL latch op and PPN and move IDLE->SEARCH.
REQ-020 Handshake: upd_valid_i SHALL be ignored outside IDLE.
REQ-021 SEARCH SHALL register the match index and match flag, plus the lowest-index free slot and free flag, then move to COMMIT.
REQ-022 COMMIT SHALL update the table, pulse upd_ack_o with upd_err_o, and return to IDLE; accept-to-ack latency is exactly 2 cycles, and the next accept is possible the cycle after ack.
REQ-023 Insert of a present PPN SHALL be a no-op with err 0.
REQ-024 Insert with no free slot SHALL leave the table unchanged with err 1.
REQ-025 Remove of an absent PPN SHALL leave the table unchanged with err 2.
REQ-026 lock_i SHALL be sampled in COMMIT; if high, the table is unchanged and err is 3, even if lock rose after accept.
REQ-027 hit_exec_ppn_o SHALL be 1 if any valid entry equals the query PPN, or if in SEARCH/COMMIT with a latched insert of that PPN (conservative pre-commit blocking).
REQ-028 A pending remove SHALL NOT clear the hit before its commit edge.
REQ-029 Table update SHALL become visible on hit_exec_ppn_o the cycle after COMMIT; count_o/full_o/empty_o SHALL update on the same edge.
REQ-030 upd_err_o SHALL read 0 whenever upd_ack_o is 0.

Reset
REQ-031 Reset SHALL clear all valid bits and return the FSM to IDLE, aborting any in-flight update with no ack.
REQ-032 During reset SHALL drive upd_ready_o=0, upd_ack_o=0, upd_err_o=0, hit_exec_ppn_o=0, count_o=0, full_o=0, empty_o=1; upd_ready_o SHALL rise the first cycle after deassertion.

Configuration
REQ-033 With EXEC_PPN_FLUSH_EN defined, SHALL add input flush_i (1 bit): when high in IDLE with lock_i=0, it clears all entries in one cycle, has priority over a same-cycle upd_valid_i (upd_ready_o=0 that cycle), and is ignored when lock_i=1 or outside IDLE.
REQ-034 Without EXEC_PPN_FLUSH_EN, flush_i SHALL be absent and entries leave only via remove.

Verification
REQ-035 Insert 0x12345, then query 0x12345ABC -> ack 2 cycles after accept with err 0, hit=1, count=1.
REQ-036 Insert 8 distinct PPNs, then a 9th (DEPTH=8) -> full_o=1, 9th err 1, count stays 8, 9th not hit.
REQ-037 Remove 0x00AAA when absent -> err 2; insert then remove 0x00AAA -> hit stays 1 through COMMIT and is 0 the cycle after ack.
REQ-038 Accept insert 0x00BBB, raise lock_i during SEARCH -> err 3, count unchanged, hit=1 only during SEARCH/COMMIT.
REQ-039 Assert rst_ni low in SEARCH -> no ack, count 0, hit 0, ready 1 the first cycle after release.
REQ-040 With EXEC_PPN_FLUSH_EN: 3 entries, flush_i and upd_valid_i together in IDLE with lock_i=0 -> count 0, update not accepted; repeat with lock_i=1 -> count stays 3.
